// File: rtl/bcd_seq_converter_pkg.sv
// Shared FSM encoding, active-low 7-segment glyphs and the digit-to-glyph
// lookup used by the binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7_code(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bcd_seq_converter_seg7.sv
// Combinational single-digit 7-segment decoder with a blank override.
module seg7_decoder
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Glyph selection; blank wins over the digit code
    always_comb begin
        seg_o = SEG_BLANK;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            seg_o = seg7_code(digit_i);
        end
    end

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative double-dabble binary-to-BCD converter with start/busy/done handshake,
// overflow saturation, leading-zero blanking and registered 7-segment outputs.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int N      = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N-1:0]          bin_in,
    input  logic                  blank_en,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   seg_out
);

    localparam int SW = 4*DIGITS + N;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         scratch_q, scratch_d;
    logic                  ovf_q, ovf_d;
    logic                  blank_q, blank_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [7*DIGITS-1:0]   seg_q, seg_d;

    logic [SW-1:0]         adj_s;
    logic [SW-1:0]         shifted_s;
    logic                  fin_ovf_s;
    logic [4*DIGITS-1:0]   fin_bcd_s;
    logic [DIGITS-1:0]     blank_s;
    logic [7*DIGITS-1:0]   seg_s;
    logic                  nz_seen_s;

    // One double-dabble step plus the final digit view used when results register.
    // A 1 leaving the top digit means the value no longer fits; saturate to all 9s.
    always_comb begin
        adj_s     = scratch_q;
        shifted_s = {SW{1'b0}};
        fin_ovf_s = 1'b0;
        fin_bcd_s = {(4*DIGITS){1'b0}};
        blank_s   = {DIGITS{1'b0}};
        nz_seen_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[N+4*i +: 4] >= 4'd5) begin
                adj_s[N+4*i +: 4] = scratch_q[N+4*i +: 4] + 4'd3;
            end else begin
                adj_s[N+4*i +: 4] = scratch_q[N+4*i +: 4];
            end
        end
        shifted_s = {adj_s[SW-2:0], 1'b0};
        fin_ovf_s = ovf_q | adj_s[SW-1];
        for (int i = 0; i < DIGITS; i++) begin
            if (fin_ovf_s) begin
                fin_bcd_s[4*i +: 4] = 4'h9;
            end else begin
                fin_bcd_s[4*i +: 4] = shifted_s[N+4*i +: 4];
            end
        end
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (fin_bcd_s[4*i +: 4] != 4'h0) begin
                nz_seen_s = 1'b1;
            end else begin
                nz_seen_s = nz_seen_s;
            end
            blank_s[i] = blank_q & ~fin_ovf_s & ~nz_seen_s;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seg7_decoder u_seg7 (
            .digit_i (fin_bcd_s[4*g +: 4]),
            .blank_i (blank_s[g]),
            .seg_o   (seg_s[7*g +: 7])
        );
    end

    // Next-state and output-register logic for the IDLE/SHIFT/DONE sequence
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scratch_d  = scratch_q;
        ovf_d      = ovf_q;
        blank_d    = blank_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        bcd_d      = bcd_q;
        seg_d      = seg_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    cnt_d     = {CW{1'b0}};
                    scratch_d = {{(4*DIGITS){1'b0}}, bin_in};
                    ovf_d     = 1'b0;
                    blank_d   = blank_en;
                    busy_d    = 1'b1;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            SHIFT: begin
                scratch_d = shifted_s;
                ovf_d     = fin_ovf_s;
                if (cnt_q == LAST_CNT) begin
                    state_d    = DONE;
                    cnt_d      = {CW{1'b0}};
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    overflow_d = fin_ovf_s;
                    bcd_d      = fin_bcd_s;
                    seg_d      = seg_s;
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= {CW{1'b0}};
            scratch_q  <= {SW{1'b0}};
            ovf_q      <= 1'b0;
            blank_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= {(4*DIGITS){1'b0}};
            seg_q      <= {DIGITS{SEG_BLANK}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scratch_q  <= scratch_d;
            ovf_q      <= ovf_d;
            blank_q    <= blank_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            bcd_q      <= bcd_d;
            seg_q      <= seg_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign bcd_out  = bcd_q;
    assign seg_out  = seg_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: a 10-bit/4-digit and a 14-bit/3-digit instance.
module tb_bcd_seq_converter;

    typedef struct packed {
        logic [23:0] bcd;
        logic [41:0] seg;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [9:0]  bin_a = 10'd0;
    logic [13:0] bin_b = 14'd0;
    logic        blank_a = 1'b0, blank_b = 1'b0;
    logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [15:0] bcd_a;
    logic [11:0] bcd_b;
    logic [27:0] seg_a;
    logic [20:0] seg_b;

    int   n_checks = 0;
    int   n_errors = 0;
    int   ph_a = 0, ph_b = 0;
    exp_t qa[$], qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;

    bcd_seq_converter #(.N(10), .DIGITS(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a), .blank_en(blank_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .bcd_out(bcd_a), .seg_out(seg_a)
    );

    bcd_seq_converter #(.N(14), .DIGITS(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b), .blank_en(blank_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .bcd_out(bcd_b), .seg_out(seg_b)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    function automatic exp_t model(input int unsigned v, input logic bl, input int d);
        exp_t        e;
        int unsigned p;
        int          msd;
        logic [3:0]  dg [0:5];
        e = '0;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        e.ovf = (v >= p);
        msd = 0;
        p = 1;
        for (int i = 0; i < d; i++) begin
            dg[i] = e.ovf ? 4'd9 : 4'((v / p) % 10);
            if (dg[i] != 4'd0) msd = i;
            p = p * 10;
        end
        for (int i = 0; i < d; i++) begin
            e.bcd[4*i +: 4] = dg[i];
            e.seg[7*i +: 7] = (bl && !e.ovf && i > msd) ? 7'h7F : glyph(dg[i]);
        end
        return e;
    endfunction

    // Reference handshake model: phase N+1 after acceptance counts down, 1 = done cycle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_a <= 0;
            ph_b <= 0;
            qa.delete();
            qb.delete();
        end else begin
            if (ph_a == 0 && start_a) begin
                qa.push_back(model(32'(bin_a), blank_a, 4));
                ph_a <= 11;
            end else if (ph_a > 0) begin
                ph_a <= ph_a - 1;
            end
            if (ph_b == 0 && start_b) begin
                qb.push_back(model(32'(bin_b), blank_b, 3));
                ph_b <= 15;
            end else if (ph_b > 0) begin
                ph_b <= ph_b - 1;
            end
        end
    end

    // Per-cycle handshake checks and scoreboard pops on the expected done cycle
    always @(negedge clk) begin
        check_val("busy_a", 64'(busy_a), 64'(ph_a >= 2));
        check_val("done_a", 64'(done_a), 64'(ph_a == 1));
        check_val("busy_b", 64'(busy_b), 64'(ph_b >= 2));
        check_val("done_b", 64'(done_b), 64'(ph_b == 1));
        if (ph_a == 1) begin
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                check_val("bcd_a", 64'(bcd_a), 64'(ea.bcd));
                check_val("seg_a", 64'(seg_a), 64'(ea.seg));
                check_val("ovf_a", 64'(ovf_a), 64'(ea.ovf));
            end else begin
                check_val("sb_empty_a", 64'd1, 64'd0);
            end
        end
        if (ph_b == 1) begin
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                check_val("bcd_b", 64'(bcd_b), 64'(eb.bcd));
                check_val("seg_b", 64'(seg_b), 64'(eb.seg));
                check_val("ovf_b", 64'(ovf_b), 64'(eb.ovf));
            end else begin
                check_val("sb_empty_b", 64'd1, 64'd0);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ph_a == 0 && ph_b == 0) return;
        end
        check_val("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic conv_a(input logic [9:0] v, input logic bl);
        @(negedge clk);
        bin_a = v; blank_a = bl; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_idle();
    endtask

    task automatic conv_b(input logic [13:0] v, input logic bl);
        @(negedge clk);
        bin_b = v; blank_b = bl; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_idle();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_bcd_a", 64'(bcd_a), 64'd0);
        check_val("rst_seg_a", 64'(seg_a), 64'h0FFF_FFFF);
        check_val("rst_ovf_a", 64'(ovf_a), 64'd0);
        check_val("rst_seg_b", 64'(seg_b), 64'h1F_FFFF);
        rst = 1'b0;

        conv_a(10'd0, 1'b0);
        check_val("zero_bcd", 64'(bcd_a), 64'h0000);
        check_val("zero_seg", 64'(seg_a), 64'(28'h810_2040));
        conv_a(10'd1023, 1'b1);
        check_val("max_bcd", 64'(bcd_a), 64'h1023);
        check_val("max_seg", 64'(seg_a), 64'({7'h79, 7'h40, 7'h24, 7'h30}));
        conv_a(10'd7, 1'b1);
        check_val("blank_on", 64'(seg_a), 64'({7'h7F, 7'h7F, 7'h7F, 7'h78}));
        conv_a(10'd7, 1'b0);
        check_val("blank_off", 64'(seg_a), 64'({7'h40, 7'h40, 7'h40, 7'h78}));
        conv_a(10'd0, 1'b1);
        check_val("blank_zero", 64'(seg_a), 64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

        conv_b(14'd1000, 1'b1);
        check_val("ovf_flag", 64'(ovf_b), 64'd1);
        check_val("ovf_bcd", 64'(bcd_b), 64'h999);
        check_val("ovf_seg", 64'(seg_b), 64'({7'h10, 7'h10, 7'h10}));
        conv_b(14'd999, 1'b0);
        check_val("ovf_clear", 64'(ovf_b), 64'd0);
        conv_b(14'd16383, 1'b0);

        // Start held high with changing data: only IDLE acceptances count
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start_a = 1'b1; bin_a = 10'($urandom_range(0, 1023)); blank_a = 1'($urandom);
            start_b = 1'b1; bin_b = 14'($urandom_range(0, 16383)); blank_b = 1'($urandom);
        end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        wait_idle();

        // Reset in the fifth SHIFT cycle aborts the conversion
        @(negedge clk);
        bin_a = 10'd300; blank_a = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("abort_busy", 64'(busy_a), 64'd0);
        check_val("abort_seg", 64'(seg_a), 64'h0FFF_FFFF);
        check_val("abort_bcd", 64'(bcd_a), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        conv_a(10'd512, 1'b0);
        check_val("after_rst", 64'(bcd_a), 64'h0512);

        for (int i = 0; i < 1000; i++) begin
            conv_a(10'($urandom_range(0, 1023)), 1'($urandom));
        end
        for (int i = 0; i < 200; i++) begin
            conv_b(14'($urandom_range(0, 16383)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
